fwd_scoreboard: RTL and testbench

Parametrised successor to the per-operand forwarding muxes. It holds a shift-register scoreboard of in-flight register writers from EX through WB, DEPTH stages deep. For NPORT read ports in ID it selects the youngest matching producer's data and raises a stall when that producer's result is not yet available, for example on a load-use hazard. It also keeps a saturating stall-cycle counter for performance bring-up.

---
 rtl/fwd_scoreboard.sv | 95 +++++++++
 tb/tb_fwd_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight writer scoreboard with per-port operand forwarding and stall
// Tracks register writers from EX to WB and resolves ID read operands against them.
module fwd_scoreboard #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NPORT = 2,
  parameter int DEPTH = 3,
  parameter int SW    = 2,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   iss_valid,
  input  logic                   iss_wr,
  input  logic [AW-1:0]          iss_dst,
  input  logic [SW-1:0]          iss_avl,
  input  logic [NPORT-1:0]       rd_en,
  input  logic [NPORT*AW-1:0]    rd_reg,
  input  logic [NPORT*DW-1:0]    rd_prev,
  input  logic [DEPTH*DW-1:0]    stg_data,
  output logic [NPORT*DW-1:0]    fwd_data,
  output logic [NPORT-1:0]       fwd_hit,
  output logic                   stall,
  input  logic                   clr_cnt,
  output logic [CW-1:0]          stall_cnt
);

  logic [DEPTH-1:0] ent_v;
  logic [AW-1:0]    ent_dst [DEPTH];
  logic [SW-1:0]    ent_avl [DEPTH];

  logic [NPORT-1:0] port_stall;
  logic             new_v;
  logic [SW-1:0]    avl_clamp;

  assign new_v     = iss_valid & iss_wr & (iss_dst != '0) & ~stall & ~flush;
  assign avl_clamp = (int'(iss_avl) > DEPTH - 1) ? SW'(DEPTH - 1) : iss_avl;
  assign stall     = |(rd_en & port_stall);

  // First match scanning from EX outward is the youngest producer; it alone decides.
  always_comb begin
    fwd_data   = rd_prev;
    fwd_hit    = '0;
    port_stall = '0;
    for (int p = 0; p < NPORT; p++) begin
      logic          found;
      logic [AW-1:0] reg_idx;
      found   = 1'b0;
      reg_idx = rd_reg[p*AW +: AW];
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && ent_v[k] && (ent_dst[k] == reg_idx) && (reg_idx != '0)) begin
          found = 1'b1;
          if (k >= int'(ent_avl[k])) begin
            fwd_data[p*DW +: DW] = stg_data[k*DW +: DW];
            fwd_hit[p]           = 1'b1;
          end else begin
            port_stall[p] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_v[k]   <= 1'b0;
        ent_dst[k] <= '0;
        ent_avl[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_v[k]   <= ent_v[k-1];
        ent_dst[k] <= ent_dst[k-1];
        ent_avl[k] <= ent_avl[k-1];
      end
      ent_v[0]   <= new_v;
      ent_dst[0] <= iss_dst;
      ent_avl[0] <= avl_clamp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall && !hold && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_fwd_scoreboard;
  localparam int DW = 32, AW = 5, NPORT = 2, DEPTH = 3, SW = 2, CW = 4;
  localparam logic [63:0] PREV = {32'h22222222, 32'h11111111};

  logic                clk = 1'b0;
  logic                reset, hold, flush, iss_valid, iss_wr, clr_cnt, stall;
  logic [AW-1:0]       iss_dst;
  logic [SW-1:0]       iss_avl;
  logic [NPORT-1:0]    rd_en, fwd_hit;
  logic [NPORT*AW-1:0] rd_reg;
  logic [NPORT*DW-1:0] rd_prev, fwd_data;
  logic [DEPTH*DW-1:0] stg_data;
  logic [CW-1:0]       stall_cnt;
  int checks = 0, errors = 0;

  fwd_scoreboard #(.DW(DW), .AW(AW), .NPORT(NPORT), .DEPTH(DEPTH), .SW(SW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .iss_valid(iss_valid),
    .iss_wr(iss_wr), .iss_dst(iss_dst), .iss_avl(iss_avl), .rd_en(rd_en), .rd_reg(rd_reg),
    .rd_prev(rd_prev), .stg_data(stg_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
    .stall(stall), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    hold = 0; flush = 0; iss_valid = 0; iss_wr = 0; iss_dst = 0; iss_avl = 0;
    rd_en = 0; rd_reg = 0; clr_cnt = 0; stg_data = 0; rd_prev = PREV;
  endtask

  task automatic issue(input logic [AW-1:0] dst, input logic [SW-1:0] avl);
    iss_valid = 1; iss_wr = 1; iss_dst = dst; iss_avl = avl;
  endtask

  task automatic drain();
    defaults();
    clr_cnt = 1;
    repeat (DEPTH) tick();
    clr_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    defaults();
    reset = 0;
    rd_reg = {5'd8, 5'd8}; rd_en = 2'b11;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_hit got %b exp 00", fwd_hit); end
    checks++; if (fwd_data !== PREV) begin errors++; $display("FAIL reset_data got %h exp %h", fwd_data, PREV); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    tick();
    reset = 1;
  endtask

  task automatic test_alu_to_alu();
    drain();
    issue(5'd8, 2'd0);
    tick();
    defaults();
    rd_reg = {5'd3, 5'd8}; rd_en = 2'b01; stg_data = {32'h0, 32'h0, 32'h00001234};
    #1;
    checks++; if (fwd_data[31:0] !== 32'h00001234) begin errors++; $display("FAIL alu_ex_data got %h exp 00001234", fwd_data[31:0]); end
    checks++; if (fwd_hit !== 2'b01) begin errors++; $display("FAIL alu_ex_hit got %b exp 01", fwd_hit); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_ex_stall got %b exp 0", stall); end
    checks++; if (fwd_data[63:32] !== 32'h22222222) begin errors++; $display("FAIL alu_other_port got %h exp 22222222", fwd_data[63:32]); end
    tick();
    stg_data = {32'h0, 32'h00005678, 32'h0};
    #1;
    checks++; if (fwd_data[31:0] !== 32'h00005678) begin errors++; $display("FAIL alu_mem_data got %h exp 00005678", fwd_data[31:0]); end
    tick();
    stg_data = {32'h00009ABC, 32'h0, 32'h0};
    #1;
    checks++; if (fwd_data[31:0] !== 32'h00009ABC) begin errors++; $display("FAIL alu_wb_data got %h exp 00009abc", fwd_data[31:0]); end
    tick();
    checks++; if (fwd_hit[0] !== 1'b0 || fwd_data[31:0] !== 32'h11111111) begin
      errors++; $display("FAIL alu_retired got hit %b data %h exp 0 11111111", fwd_hit[0], fwd_data[31:0]); end
  endtask

  task automatic test_load_use();
    drain();
    issue(5'd9, 2'd1);
    tick();
    issue(5'd10, 2'd0);
    rd_reg = {5'd10, 5'd9}; rd_en = 2'b01;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    checks++; if (fwd_hit[0] !== 1'b0 || fwd_data[31:0] !== 32'h11111111) begin
      errors++; $display("FAIL lu_stall_data got hit %b data %h exp 0 11111111", fwd_hit[0], fwd_data[31:0]); end
    tick();
    stg_data = {32'h0, 32'hCAFEF00D, 32'h0};
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall); end
    checks++; if (fwd_data[31:0] !== 32'hCAFEF00D || fwd_hit[0] !== 1'b1) begin
      errors++; $display("FAIL lu_fwd got hit %b data %h exp 1 cafef00d", fwd_hit[0], fwd_data[31:0]); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    checks++; if (fwd_hit[1] !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", fwd_hit[1]); end
    // One unrelated instruction between load and consumer hides the load latency.
    drain();
    issue(5'd11, 2'd1);
    tick();
    issue(5'd12, 2'd0);
    tick();
    defaults();
    rd_reg = {5'd0, 5'd11}; rd_en = 2'b01; stg_data = {32'h0, 32'h0BADBEEF, 32'h0};
    #1;
    checks++; if (stall !== 1'b0 || fwd_data[31:0] !== 32'h0BADBEEF) begin
      errors++; $display("FAIL lu_gap got stall %b data %h exp 0 0badbeef", stall, fwd_data[31:0]); end
  endtask

  task automatic test_youngest();
    drain();
    issue(5'd5, 2'd0); tick();
    issue(5'd6, 2'd0); tick();
    issue(5'd5, 2'd0); tick();
    issue(5'd5, 2'd1);
    rd_reg = {5'd5, 5'd5}; rd_en = 2'b11; stg_data = {32'hB, 32'h0, 32'hA};
    #1;
    checks++; if (fwd_data !== {32'hA, 32'hA}) begin errors++; $display("FAIL yng_data got %h exp both 0000000a", fwd_data); end
    checks++; if (fwd_hit !== 2'b11 || stall !== 1'b0) begin errors++; $display("FAIL yng_hit got hit %b stall %b exp 11 0", fwd_hit, stall); end
    tick();
    checks++; if (stall !== 1'b1 || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL yng_unavail got stall %b hit %b exp 1 00", stall, fwd_hit); end
    rd_en = 2'b00;
    #1;
    checks++; if (stall !== 1'b0 || fwd_data !== PREV) begin
      errors++; $display("FAIL yng_rd_en_off got stall %b data %h exp 0 %h", stall, fwd_data, PREV); end
  endtask

  task automatic test_zero_reg();
    drain();
    issue(5'd0, 2'd1); tick();
    issue(5'd0, 2'd0); tick();
    defaults();
    rd_prev = {32'h22222222, 32'h0}; rd_reg = {5'd0, 5'd0}; rd_en = 2'b01;
    stg_data = {32'h0, 32'hDEAD, 32'hDEAD};
    #1;
    checks++; if (fwd_hit[0] !== 1'b0 || fwd_data[31:0] !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL zero_reg got hit %b data %h stall %b exp 0 0 0", fwd_hit[0], fwd_data[31:0], stall); end
  endtask

  task automatic test_hold_stall();
    drain();
    issue(5'd9, 2'd1); tick();
    issue(5'd10, 2'd0);
    rd_reg = {5'd0, 5'd9}; rd_en = 2'b01; hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
        errors++; $display("FAIL hold_%0d got stall %b cnt %0d exp 1 0", i, stall, stall_cnt); end
      tick();
    end
    hold = 0;
    #1;
    checks++; if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL hold_release got stall %b cnt %0d exp 1 0", stall, stall_cnt); end
    tick();
    stg_data = {32'h0, 32'h600DF00D, 32'h0};
    #1;
    checks++; if (stall !== 1'b0 || stall_cnt !== 4'd1 || fwd_data[31:0] !== 32'h600DF00D) begin
      errors++; $display("FAIL hold_after got stall %b cnt %0d data %h exp 0 1 600df00d", stall, stall_cnt, fwd_data[31:0]); end
  endtask

  task automatic test_flush();
    drain();
    issue(5'd13, 2'd0); flush = 1; tick();
    defaults();
    rd_reg = {5'd0, 5'd13}; rd_en = 2'b01;
    #1;
    checks++; if (fwd_hit[0] !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL flush_bubble got hit %b stall %b exp 0 0", fwd_hit[0], stall); end
    defaults();
    issue(5'd9, 2'd1); tick();
    issue(5'd10, 2'd0); flush = 1;
    rd_reg = {5'd10, 5'd9}; rd_en = 2'b01;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b exp 1", stall); end
    tick();
    checks++; if (stall_cnt !== 4'd1 || fwd_hit[1] !== 1'b0) begin
      errors++; $display("FAIL flush_stall_cnt got cnt %0d hit1 %b exp 1 0", stall_cnt, fwd_hit[1]); end
  endtask

  task automatic test_avl_clamp();
    drain();
    issue(5'd14, 2'd3); tick();
    defaults();
    rd_reg = {5'd0, 5'd14}; rd_en = 2'b01; stg_data = {32'h77777777, 32'h0, 32'h0};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clamp_ex got %b exp 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clamp_mem got %b exp 1", stall); end
    tick();
    checks++; if (stall !== 1'b0 || fwd_data[31:0] !== 32'h77777777) begin
      errors++; $display("FAIL clamp_wb got stall %b data %h exp 0 77777777", stall, fwd_data[31:0]); end
  endtask

  task automatic test_saturation();
    drain();
    for (int i = 0; i < 20; i++) begin
      defaults();
      issue(5'd9, 2'd1); tick();
      defaults();
      rd_reg = {5'd0, 5'd9}; rd_en = 2'b01; tick();
    end
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
    defaults();
    issue(5'd9, 2'd1); tick();
    defaults();
    rd_reg = {5'd0, 5'd9}; rd_en = 2'b01; clr_cnt = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clr_stall got %b exp 1", stall); end
    tick();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    drain();
    issue(5'd9, 2'd2); tick();
    defaults();
    rd_reg = {5'd9, 5'd9}; rd_en = 2'b11; tick();
    checks++; if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL mid_pre got stall %b cnt %0d exp 1 1", stall, stall_cnt); end
    #2;
    reset = 0;
    #1;
    checks++; if (stall !== 1'b0 || fwd_hit !== 2'b00 || fwd_data !== PREV) begin
      errors++; $display("FAIL mid_reset got stall %b hit %b data %h exp 0 00 %h", stall, fwd_hit, fwd_data, PREV); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d exp 0", stall_cnt); end
    tick();
    reset = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_after got %b exp 0", stall); end
  endtask

  initial begin
    test_reset();
    test_alu_to_alu();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_hold_stall();
    test_flush();
    test_avl_clamp();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end
endmodule
